// File: rtl/avalon_st_seq_source.sv
// Avalon-ST source that emits a packet of COUNT beats following an arithmetic sequence.
// Supports optional inter-beat idle gaps, repeat mode and a start/done handshake.
module avalon_st_seq_source #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned START_VAL = 4,
    parameter int unsigned STEP      = 1,
    parameter int unsigned COUNT     = 3,
    parameter int unsigned GAP       = 0,
    parameter bit          REPEAT    = 1'b0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              startofpacket,
    output logic              endofpacket,
    output logic              busy,
    output logic              done
);

    localparam int unsigned IdxW = $clog2(COUNT + 1);
    localparam int unsigned GapW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [DATA_W-1:0] StartV   = DATA_W'(START_VAL);
    localparam logic [DATA_W-1:0] StepV    = DATA_W'(STEP);
    localparam logic [IdxW-1:0]   IdxLast  = IdxW'(COUNT - 1);
    localparam logic [GapW-1:0]   GapLast  = (GAP > 0) ? GapW'(GAP - 1) : '0;
    localparam bit                FirstEop = (COUNT == 1);
    localparam bit                HasGap   = (GAP > 0);

    typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [GapW-1:0]     gap_q, gap_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                sop_q, sop_d;
    logic                eop_q, eop_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [IdxW-1:0]     idx_nxt;

    assign idx_nxt = idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        valid_d = valid_q;
        data_d  = data_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        busy_d  = busy_q;
        done_d  = done_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StSend;
                    idx_d   = '0;
                    gap_d   = '0;
                    valid_d = 1'b1;
                    data_d  = StartV;
                    sop_d   = 1'b1;
                    eop_d   = FirstEop;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            StSend: begin
                if (valid_q && ready) begin
                    if (eop_q && !REPEAT) begin
                        state_d = StDone;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Precompute the next beat; in GAP it stays parked in data_q.
                        if (eop_q) begin
                            idx_d  = '0;
                            data_d = StartV;
                            sop_d  = 1'b1;
                            eop_d  = FirstEop;
                        end else begin
                            idx_d  = idx_nxt;
                            data_d = data_q + StepV;
                            sop_d  = 1'b0;
                            eop_d  = (idx_nxt == IdxLast);
                        end
                        if (HasGap) begin
                            state_d = StGap;
                            valid_d = 1'b0;
                            gap_d   = '0;
                        end
                    end
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StSend;
                    valid_d = 1'b1;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            idx_q   <= '0;
            gap_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign valid         = valid_q;
    assign data          = data_q;
    assign startofpacket = sop_q;
    assign endofpacket   = eop_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_avalon_st_seq_source.sv
// Directed bench for avalon_st_seq_source: several parameterisations share one clock and reset.
module tb_avalon_st_seq_source;

    logic clk;
    logic resetn;

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance: START_VAL=4, STEP=1, COUNT=3, GAP=0, REPEAT=0
    logic       start_def, ready_def, valid_def, sop_def, eop_def, busy_def, done_def;
    logic [7:0] data_def;
    avalon_st_seq_source u_def (
        .clk(clk), .resetn(resetn), .start(start_def), .ready(ready_def),
        .valid(valid_def), .data(data_def), .startofpacket(sop_def),
        .endofpacket(eop_def), .busy(busy_def), .done(done_def)
    );

    logic       start_gap, valid_gap, sop_gap, eop_gap, busy_gap, done_gap;
    logic [7:0] data_gap;
    avalon_st_seq_source #(.GAP(2)) u_gap (
        .clk(clk), .resetn(resetn), .start(start_gap), .ready(1'b1),
        .valid(valid_gap), .data(data_gap), .startofpacket(sop_gap),
        .endofpacket(eop_gap), .busy(busy_gap), .done(done_gap)
    );

    logic       start_w, valid_w1, sop_w1, eop_w1, busy_w1, done_w1;
    logic [7:0] data_w1;
    avalon_st_seq_source #(.START_VAL(254), .STEP(1), .COUNT(4)) u_wrap1 (
        .clk(clk), .resetn(resetn), .start(start_w), .ready(1'b1),
        .valid(valid_w1), .data(data_w1), .startofpacket(sop_w1),
        .endofpacket(eop_w1), .busy(busy_w1), .done(done_w1)
    );

    logic       valid_w3, sop_w3, eop_w3, busy_w3, done_w3;
    logic [7:0] data_w3;
    avalon_st_seq_source #(.START_VAL(250), .STEP(3), .COUNT(4)) u_wrap3 (
        .clk(clk), .resetn(resetn), .start(start_w), .ready(1'b1),
        .valid(valid_w3), .data(data_w3), .startofpacket(sop_w3),
        .endofpacket(eop_w3), .busy(busy_w3), .done(done_w3)
    );

    logic       start_rep, valid_rep, sop_rep, eop_rep, busy_rep, done_rep;
    logic [7:0] data_rep;
    avalon_st_seq_source #(.COUNT(2), .REPEAT(1'b1)) u_rep (
        .clk(clk), .resetn(resetn), .start(start_rep), .ready(1'b1),
        .valid(valid_rep), .data(data_rep), .startofpacket(sop_rep),
        .endofpacket(eop_rep), .busy(busy_rep), .done(done_rep)
    );

    logic       start_one, valid_one, sop_one, eop_one, busy_one, done_one;
    logic [7:0] data_one;
    avalon_st_seq_source #(.COUNT(1)) u_one (
        .clk(clk), .resetn(resetn), .start(start_one), .ready(1'b1),
        .valid(valid_one), .data(data_one), .startofpacket(sop_one),
        .endofpacket(eop_one), .busy(busy_one), .done(done_one)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Packs {valid, sop, eop, busy, done, data} of the default instance.
    function automatic logic [31:0] st_def();
        return {19'd0, valid_def, sop_def, eop_def, busy_def, done_def, data_def};
    endfunction

    function automatic logic [31:0] exp_st(input logic v, input logic s, input logic e,
                                           input logic b, input logic d, input logic [7:0] x);
        return {19'd0, v, s, e, b, d, x};
    endfunction

    logic [7:0] w1_exp [4];
    logic [7:0] w3_exp [4];

    initial begin
        resetn    = 1'b0;
        start_def = 1'b0;
        ready_def = 1'b1;
        start_gap = 1'b0;
        start_w   = 1'b0;
        start_rep = 1'b0;
        start_one = 1'b0;
        w1_exp    = '{8'd254, 8'd255, 8'd0, 8'd1};
        w3_exp    = '{8'd250, 8'd253, 8'd0, 8'd3};

        step();
        check_eq("reset_state", st_def(), exp_st(0, 0, 0, 0, 0, 8'd0));
        step();
        resetn = 1'b1;
        step();
        check_eq("idle_no_valid", st_def(), exp_st(0, 0, 0, 0, 0, 8'd0));

        // Test 1: back-to-back beats then DONE
        start_def = 1'b1;
        step();
        start_def = 1'b0;
        check_eq("t1_beat4", st_def(), exp_st(1, 1, 0, 1, 0, 8'd4));
        step();
        check_eq("t1_beat5", st_def(), exp_st(1, 0, 0, 1, 0, 8'd5));
        step();
        check_eq("t1_beat6", st_def(), exp_st(1, 0, 1, 1, 0, 8'd6));
        step();
        check_eq("t1_done", st_def(), exp_st(0, 0, 1, 0, 1, 8'd6));
        step();
        check_eq("t1_done_hold", {31'd0, done_def}, 32'd1);

        // Test 2: backpressure while beat 5 is presented; restart from DONE
        start_def = 1'b1;
        step();
        start_def = 1'b0;
        check_eq("t2_beat4", st_def(), exp_st(1, 1, 0, 1, 0, 8'd4));
        step();
        ready_def = 1'b0;
        check_eq("t2_hold0", st_def(), exp_st(1, 0, 0, 1, 0, 8'd5));
        step();
        check_eq("t2_hold1", st_def(), exp_st(1, 0, 0, 1, 0, 8'd5));
        step();
        check_eq("t2_hold2", st_def(), exp_st(1, 0, 0, 1, 0, 8'd5));
        ready_def = 1'b1;
        step();
        check_eq("t2_beat6", st_def(), exp_st(1, 0, 1, 1, 0, 8'd6));
        step();
        check_eq("t2_done", st_def(), exp_st(0, 0, 1, 0, 1, 8'd6));

        // Test 3: GAP=2 -> 4 _ _ 5 _ _ 6
        start_gap = 1'b1;
        step();
        start_gap = 1'b0;
        check_eq("t3_beat4", {valid_gap, sop_gap, data_gap}, {1'b1, 1'b1, 8'd4});
        step();
        check_eq("t3_gap_a0", {valid_gap, busy_gap}, 2'b01);
        step();
        check_eq("t3_gap_a1", {valid_gap, busy_gap}, 2'b01);
        step();
        check_eq("t3_beat5", {valid_gap, sop_gap, eop_gap, data_gap}, {3'b100, 8'd5});
        step();
        check_eq("t3_gap_b0", {31'd0, valid_gap}, 32'd0);
        step();
        check_eq("t3_gap_b1", {31'd0, valid_gap}, 32'd0);
        step();
        check_eq("t3_beat6", {valid_gap, sop_gap, eop_gap, data_gap}, {3'b101, 8'd6});
        step();
        check_eq("t3_done", {valid_gap, busy_gap, done_gap}, 3'b001);

        // Test 4: wraparound modulo 2^8
        start_w = 1'b1;
        step();
        start_w = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t4_wrap1_beat%0d", i),
                     {valid_w1, sop_w1, eop_w1, data_w1}, {1'b1, i == 0, i == 3, w1_exp[i]});
            check_eq($sformatf("t4_wrap3_beat%0d", i),
                     {valid_w3, sop_w3, eop_w3, data_w3}, {1'b1, i == 0, i == 3, w3_exp[i]});
            step();
        end
        check_eq("t4_wrap1_done", {valid_w1, done_w1}, 2'b01);
        check_eq("t4_wrap3_done", {valid_w3, done_w3}, 2'b01);

        // Test 5: REPEAT with COUNT=2, start toggling ignored
        start_rep = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            start_rep = ~start_rep;
            check_eq($sformatf("t5_beat%0d", i),
                     {valid_rep, sop_rep, eop_rep, busy_rep, done_rep, data_rep},
                     {1'b1, (i % 2) == 0, (i % 2) == 1, 1'b1, 1'b0,
                      ((i % 2) == 0) ? 8'd4 : 8'd5});
            step();
        end
        start_rep = 1'b0;

        // Test 6: asynchronous reset mid-packet with ready low
        start_def = 1'b1;
        step();
        start_def = 1'b0;
        step();
        ready_def = 1'b0;
        check_eq("t6_pre_beat5", st_def(), exp_st(1, 0, 0, 1, 0, 8'd5));
        #2;
        resetn = 1'b0;
        #1;
        check_eq("t6_async_reset", st_def(), exp_st(0, 0, 0, 0, 0, 8'd0));
        check_eq("t6_rep_reset", {valid_rep, busy_rep}, 2'b00);
        step();
        resetn    = 1'b1;
        ready_def = 1'b1;
        step();
        step();
        check_eq("t6_idle_after", st_def(), exp_st(0, 0, 0, 0, 0, 8'd0));
        check_eq("t6_rep_idle", {31'd0, valid_rep}, 32'd0);
        start_def = 1'b1;
        step();
        start_def = 1'b0;
        check_eq("t6_restart4", st_def(), exp_st(1, 1, 0, 1, 0, 8'd4));

        // COUNT=1: single beat with sop and eop together
        start_one = 1'b1;
        step();
        start_one = 1'b0;
        check_eq("t6_one_beat", {valid_one, sop_one, eop_one, busy_one, data_one},
                 {4'b1111, 8'd4});
        step();
        check_eq("t6_one_done", {valid_one, busy_one, done_one}, 3'b001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
